// File: rtl/imem_load_arbiter.sv
// rtl/imem_load_arbiter.sv - shares the instruction-memory port between CPU fetch and a program loader
module imem_load_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int MAX_CONSEC = 4,
    parameter int BOOT_LOAD  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    output logic [DATA_W-1:0] cpu_instr,
    output logic              cpu_stall,
    output logic              cpu_run,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              ld_reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam state_t   RESET_STATE = (BOOT_LOAD != 0) ? S_LOAD : S_RUN;
    localparam logic     RESET_RUN   = (BOOT_LOAD == 0);
    localparam logic [3:0] CAP       = 4'(MAX_CONSEC);

    state_t state;
    state_t state_nxt;

    logic [3:0]        consec;
    logic              accept;
    logic              in_range;
    logic              addr_lo_ok;
    logic [ADDR_W-1:0] cpu_idx;

    // The byte-offset bits never select a word; the tautology keeps every address bit consumed.
    assign addr_lo_ok = &(cpu_addr[1:0] | ~cpu_addr[1:0]);
    assign in_range   = ~|cpu_addr[31:ADDR_W+2] & addr_lo_ok;
    assign cpu_idx    = cpu_addr[ADDR_W+1:2];

    // The loader is always welcome while loading; in run it yields once the grant cap is reached.
    assign ld_ready = (state == S_LOAD) || (consec != CAP);
    assign accept   = ld_valid & ld_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: last boot beat releases the CPU, a reload request returns to loading.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: if (accept && ld_last) state_nxt = S_RUN;
            S_RUN:  if (ld_reload) state_nxt = S_LOAD;
            default: state_nxt = RESET_STATE;
        endcase
    end

    // Port mux and CPU-facing outputs: a write owns the port and stalls the CPU for that cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = cpu_idx;
        mem_wdata = '0;
        cpu_stall = 1'b1;
        cpu_instr = '0;
        if (accept) begin
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
        end
        if (state == S_RUN && !accept) begin
            cpu_stall = 1'b0;
            if (in_range) begin
                cpu_instr = mem_rdata;
            end
        end
    end

    // Grant-run counter, beat counter and the registered CPU release.
    always_ff @(posedge clk) begin
        if (reset) begin
            consec     <= '0;
            load_count <= '0;
            cpu_run    <= RESET_RUN;
        end else begin
            cpu_run <= (state_nxt == S_RUN);
            if (state == S_LOAD) begin
                consec <= '0;
                if (accept && load_count != '1) begin
                    load_count <= load_count + 1'b1;
                end
            end else if (ld_reload) begin
                consec     <= '0;
                load_count <= '0;
            end else if (accept) begin
                consec <= consec + 4'd1;
            end else begin
                consec <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// tb/tb_imem_load_arbiter.sv - scoreboard bench for imem_load_arbiter
module tb_imem_load_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic        cpu_run;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_reload;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [8:0]  load_count;

    logic [31:0] cpu_instr0;
    logic        cpu_stall0;
    logic        cpu_run0;
    logic        ld_ready0;
    logic        mem_we0;
    logic [7:0]  mem_addr0;
    logic [31:0] mem_wdata0;
    logic [8:0]  load_count0;

    always #5 clk = ~clk;

    imem_load_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_CONSEC(4), .BOOT_LOAD(1)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_instr(cpu_instr),
        .cpu_stall(cpu_stall), .cpu_run(cpu_run), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .ld_reload(ld_reload),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .load_count(load_count)
    );

    imem_load_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_CONSEC(4), .BOOT_LOAD(0)) dut0 (
        .clk(clk), .reset(reset), .cpu_addr(32'h0), .cpu_instr(cpu_instr0),
        .cpu_stall(cpu_stall0), .cpu_run(cpu_run0), .ld_valid(1'b0), .ld_ready(ld_ready0),
        .ld_addr(8'h0), .ld_data(32'h0), .ld_last(1'b0), .ld_reload(1'b0),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(32'h0),
        .load_count(load_count0)
    );

    logic [31:0] arr [256];

    always @(posedge clk) begin
        if (mem_we) arr[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = arr[mem_addr];

    typedef struct {
        logic [31:0] instr;
        logic        stall;
        logic        run;
        logic        ready;
        logic        we;
        logic [7:0]  addr;
        logic [8:0]  cnt;
    } exp_t;

    exp_t        sbq [$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_mem [256];
    bit          m_load;
    bit          m_run;
    bit          m_known = 1'b0;
    int          m_consec;
    int          m_count;
    logic [31:0] seen_instr;
    bit          seen_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input bit rst, input logic [31:0] pc, input bit v, input logic [7:0] a,
                         input logic [31:0] d, input bit last, input bit rel);
        exp_t        e;
        exp_t        o;
        bit          acc;
        bit          inr;
        logic [7:0]  idx;
        reset     = rst;
        cpu_addr  = pc;
        ld_valid  = v;
        ld_addr   = a;
        ld_data   = d;
        ld_last   = last;
        ld_reload = rel;
        inr = (pc[31:10] == 22'h0);
        idx = pc[9:2];
        if (m_load) begin
            e.ready = 1'b1;
            acc     = v;
            e.stall = 1'b1;
            e.instr = 32'h0;
        end else begin
            e.ready = (m_consec != 4);
            acc     = v && e.ready;
            e.stall = acc;
            e.instr = (acc || !inr) ? 32'h0 : ref_mem[idx];
        end
        e.run  = m_run;
        e.we   = acc;
        e.addr = acc ? a : idx;
        e.cnt  = m_count[8:0];
        if (m_known) sbq.push_back(e);
        #3;
        seen_instr = cpu_instr;
        seen_acc   = ld_valid & ld_ready;
        if (m_known && sbq.size() > 0) begin
            o = sbq.pop_front();
            check("cpu_instr", cpu_instr, o.instr);
            check("cpu_stall", cpu_stall, o.stall);
            check("cpu_run", cpu_run, o.run);
            check("ld_ready", ld_ready, o.ready);
            check("mem_we", mem_we, o.we);
            check("mem_addr", mem_addr, o.addr);
            check("load_count", load_count, o.cnt);
            if (o.we) check("mem_wdata", mem_wdata, d);
        end
        @(posedge clk);
        #1;
        if (acc) ref_mem[a] = d;
        if (rst) begin
            m_load = 1'b1; m_run = 1'b0; m_count = 0; m_consec = 0; m_known = 1'b1;
        end else if (m_load) begin
            if (acc && m_count < 511) m_count++;
            if (acc && last) begin
                m_load = 1'b0;
                m_run  = 1'b1;
            end
            m_consec = 0;
        end else if (rel) begin
            m_load = 1'b1; m_run = 1'b0; m_count = 0; m_consec = 0;
        end else begin
            m_consec = acc ? m_consec + 1 : 0;
        end
    endtask

    task automatic fetch(input logic [31:0] pc);
        cycle(1'b0, pc, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic beat(input logic [31:0] pc, input logic [7:0] a, input logic [31:0] d,
                        input bit last, input bit rel);
        cycle(1'b0, pc, 1'b1, a, d, last, rel);
    endtask

    logic [31:0] boot_img [4];
    logic [9:0]  acc_pat;

    initial begin
        for (int i = 0; i < 256; i++) begin
            arr[i]    <= 32'h0;
            ref_mem[i] = 32'h0;
        end
        boot_img[0] = 32'h201d0400;
        boot_img[1] = 32'h8c080010;
        boot_img[2] = 32'hac080000;
        boot_img[3] = 32'h20040014;
        reset = 1'b1; cpu_addr = 32'h0; ld_valid = 1'b0; ld_addr = 8'h0;
        ld_data = 32'h0; ld_last = 1'b0; ld_reload = 1'b0;
        @(posedge clk); #1;

        // reset state
        cycle(1'b1, 32'h0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
        check("boot0_run", cpu_run0, 1'b1);
        check("boot0_stall", cpu_stall0, 1'b0);
        check("boot0_ready", ld_ready0, 1'b1);

        // boot image
        fetch(32'h4);
        for (int i = 0; i < 4; i++) beat(32'h4, 8'(i), boot_img[i], i == 3, 1'b0);
        check("t1_count", load_count, 9'd4);
        check("t1_run", cpu_run, 1'b1);
        fetch(32'h4);
        check("t1_fetch", seen_instr, 32'h8c080010);

        // grant cap
        for (int i = 0; i < 10; i++) begin
            beat(32'h8, 8'(16 + i), $urandom, 1'b0, 1'b0);
            acc_pat[i] = seen_acc;
        end
        check("t2_pattern", acc_pat, 10'b0111101111);
        fetch(32'h8);

        // patch then read-after-write
        beat(32'h14, 8'd5, 32'h0c10008f, 1'b0, 1'b0);
        fetch(32'h14);
        check("t3_patch", seen_instr, 32'h0c10008f);

        // out of range fetch
        fetch(32'h00000400);
        fetch(32'hffff0004);

        // reload with a beat in the same cycle
        beat(32'h0, 8'd7, 32'h12345678, 1'b0, 1'b1);
        fetch(32'h1c);
        check("t5_run", cpu_run, 1'b0);
        beat(32'h1c, 8'd6, 32'h0badf00d, 1'b1, 1'b1);
        fetch(32'h1c);
        check("t5_readback", seen_instr, 32'h12345678);
        fetch(32'h18);

        // saturating count, reset mid-load, partial image survives
        beat(32'h0, 8'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 515; i++) beat(32'h0, 8'(i), $urandom, 1'b0, 1'b0);
        beat(32'h0, 8'd8, 32'ha5a50008, 1'b0, 1'b0);
        beat(32'h0, 8'd9, 32'ha5a50009, 1'b0, 1'b0);
        check("t6_sat", load_count, 9'h1ff);
        cycle(1'b1, 32'h0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
        check("t6_boot0_run", cpu_run0, 1'b1);
        fetch(32'h20);
        beat(32'h20, 8'd200, 32'h00000013, 1'b1, 1'b0);
        fetch(32'h20);
        check("t6_keep8", seen_instr, 32'ha5a50008);
        fetch(32'h24);
        check("t6_keep9", seen_instr, 32'ha5a50009);
        fetch(32'h320);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Owns the single instruction-memory array and shares its one access port between two requesters: the CPU fetch path (combinational read, every cycle) and a program loader (write beats with valid/ready).
- After reset it holds the CPU in a boot-load phase until the loader delivers its last beat, then releases the CPU.
- During run it allows loader patch writes, stalling the CPU for the cycle of each write, with a consecutive-grant cap so the CPU is never starved.

Parameters:
- ADDR_W, 8: word-index width; word index = byte address bits [ADDR_W+1:2].
- DATA_W, 32: instruction width.
- MAX_CONSEC, 4: maximum back-to-back loader grants in RUN before one forced CPU cycle (range 1..15).
- BOOT_LOAD, 1: 1 = reset enters LOAD; 0 = reset enters RUN directly.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_addr  in  32  CPU fetch byte address (PC).
- cpu_instr  out  DATA_W  instruction to CPU; 32'h00000000 (nop) when not served.
- cpu_stall  out  1  CPU must not advance PC this cycle.
- cpu_run  out  1  registered; CPU held in reset while 0.
- ld_valid  in  1  loader beat valid.
- ld_ready  out  1  loader beat accepted when ld_valid & ld_ready.
- ld_addr  in  ADDR_W  target word index.
- ld_data  in  DATA_W  instruction word.
- ld_last  in  1  final beat of a boot image.
- ld_reload  in  1  single-cycle request to return to LOAD.
- mem_we  out  1  array write enable.
- mem_addr  out  ADDR_W  array word index.
- mem_wdata  out  DATA_W  array write data.
- mem_rdata  in  DATA_W  array combinational read data at mem_addr.
- load_count  out  ADDR_W+1  registered count of accepted beats since entering LOAD; saturates at all-ones.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `reset` is synchronous, active-high.
- States: LOAD, RUN. On reset, state = LOAD if BOOT_LOAD=1, else RUN; consec = 0; load_count = 0; cpu_run = (BOOT_LOAD==0). Memory contents are not cleared.
- Beat accept: accept = ld_valid & ld_ready. When accept: mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data. Otherwise: mem_we=0, mem_addr=cpu_addr[ADDR_W+1:2], mem_wdata=0.
- LOAD:
  - ld_ready=1, cpu_stall=1, cpu_instr=0, cpu_run=0.
  - Each accept increments load_count.
  - accept & ld_last -> RUN next cycle, with cpu_run=1 from that cycle.
  - ld_reload is ignored in LOAD.
- RUN:
  - ld_ready = (consec != MAX_CONSEC).
  - On accept: cpu_stall=1, cpu_instr=0, consec++. Otherwise: cpu_stall=0, cpu_instr=mem_rdata, consec=0.
  - ld_last in RUN has no effect on state (patch beat).
  - ld_reload -> LOAD next cycle: cpu_run=0, load_count=0, consec=0. A beat accepted in the same cycle as ld_reload is still written but not counted.
- Fetch range check: if cpu_addr bits [31:ADDR_W+2] are not all zero, cpu_instr=0 and the array is not read for the CPU; stall rules are unchanged.
- Latency:
  - CPU read is 0-cycle (combinational through the mux).
  - Loader write completes at the accepting edge.
  - Read-after-write: a CPU fetch of a word written in cycle N sees the new data in cycle N+1.
- Same-address conflict: write has priority; the CPU is stalled that cycle, so no torn read is possible.
- Reset mid-burst: the partial image stays in the array; state follows the BOOT_LOAD rule; the loader must restart.

Test Plan:
1. BOOT_LOAD=1, reset, then beats addr 0..3 with data 201d0400, 8c080010, ac080000, 20040014, last on beat 3 -> load_count=4; cpu_run rises the cycle after beat 3; cpu_addr=0x4 returns 8c080010 with cpu_stall=0.
2. RUN, loader holds ld_valid=1 for 10 cycles with MAX_CONSEC=4 -> accept pattern 4 on / 1 off / 4 on / 1 off; cpu_stall mirrors accept; cpu_instr=0 on stalled cycles and mem_rdata on the off cycles.
3. RUN, patch addr 5 := 0c10008f while cpu_addr=0x14 -> that cycle stalls with cpu_instr=0; the next cycle, with no beat, yields 0c10008f.
4. RUN, cpu_addr=0x00000400 (ADDR_W=8) -> cpu_instr=0, mem_we=0, cpu_stall=0.
5. ld_reload in the same cycle as an accepted beat -> beat written; next cycle state=LOAD, cpu_run=0, load_count=0; a subsequent last beat returns to RUN.
6. Reset asserted mid-load after 2 beats -> next cycle load_count=0, cpu_run=0, ld_ready=1; previously written words are still readable after a later load completes. With BOOT_LOAD=0, reset -> cpu_run=1 immediately.
